// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store router: access sizes, FSM states, cacheable window.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [31:0] LSU_CACHE_BASE  = 32'h8000_0000;
   localparam logic [31:0] LSU_CACHE_LIMIT = 32'h87ff_ffff;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CACHE = 2'd1,
      ST_DEV   = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   // An access is aligned when the low offset bits covered by its size are zero.
   function automatic logic lsu_misaligned(input logic [2:0] off, input logic [1:0] size);
      logic [3:0] span;
      span = (4'd1 << size) - 4'd1;
      return |(off & span[2:0]);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: shifts store data and builds strobes; extracts and extends load data.
// Purely combinational, no latency, no flow control.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [2:0]            st_off_i,
   input  logic [1:0]            st_size_i,
   input  logic [DATA_WIDTH-1:0] st_wdata_i,
   output logic [DATA_WIDTH-1:0] st_wdata_o,
   output logic [7:0]            st_wmask_o,
   input  logic [2:0]            ld_off_i,
   input  logic [1:0]            ld_size_i,
   input  logic                  ld_unsigned_i,
   input  logic [DATA_WIDTH-1:0] ld_raw_i,
   output logic [DATA_WIDTH-1:0] ld_data_o
);

   logic [7:0]            base_mask;
   logic [DATA_WIDTH-1:0] ld_shift;
   logic                  ext_bit;

   always_comb begin
      case (st_size_i)
         SZ_H:    base_mask = 8'h03;
         SZ_W:    base_mask = 8'h0f;
         SZ_D:    base_mask = 8'hff;
         default: base_mask = 8'h01;
      endcase
      st_wmask_o = base_mask << st_off_i;
      st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
   end

   always_comb begin
      ld_shift  = ld_raw_i >> {ld_off_i, 3'b000};
      ext_bit   = 1'b0;
      ld_data_o = ld_shift;
      case (ld_size_i)
         SZ_B: begin
            ext_bit   = ~ld_unsigned_i & ld_shift[7];
            ld_data_o = {{(DATA_WIDTH-8){ext_bit}}, ld_shift[7:0]};
         end
         SZ_H: begin
            ext_bit   = ~ld_unsigned_i & ld_shift[15];
            ld_data_o = {{(DATA_WIDTH-16){ext_bit}}, ld_shift[15:0]};
         end
         SZ_W: begin
            ext_bit   = ~ld_unsigned_i & ld_shift[31];
            ld_data_o = {{(DATA_WIDTH-32){ext_bit}}, ld_shift[31:0]};
         end
         default: ld_data_o = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_router.sv
// Registers one load/store, routes it to dcache or device port, returns extended data; accept->resp 2 cycles (1 if misaligned).
// One transaction in flight: req_ready only in IDLE, response held until resp_ready. LSU_DEV_TIMEOUT_EN adds a device timeout.
module lsu_router
   import lsu_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 64,
   parameter int          DATA_WIDTH  = 64,
   parameter logic [31:0] CACHE_BASE  = LSU_CACHE_BASE,
   parameter logic [31:0] CACHE_LIMIT = LSU_CACHE_LIMIT
`ifdef LSU_DEV_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  cache_req,
   output logic                  cache_wen,
   output logic [31:0]           cache_addr,
   output logic [DATA_WIDTH-1:0] cache_wdata,
   output logic [7:0]            cache_wmask,
   input  logic [DATA_WIDTH-1:0] cache_rdata,
   input  logic                  cache_finish,
   output logic                  dev_req,
   output logic                  dev_wen,
   output logic [31:0]           dev_addr,
   output logic [DATA_WIDTH-1:0] dev_wdata,
   output logic [7:0]            dev_wmask,
   input  logic [DATA_WIDTH-1:0] dev_rdata,
   input  logic                  dev_finish
);

   lsu_state_t            state_q, state_d;
   logic                  wen_q, uns_q, err_q;
   logic [1:0]            size_q;
   logic [2:0]            off_q;
   logic [31:0]           addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [7:0]            wmask_q;

   logic                  misal, in_cache;
   logic [DATA_WIDTH-1:0] st_wdata, ld_raw, ld_data;
   logic [7:0]            st_wmask;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:32];
   assign misal          = lsu_misaligned(req_addr[2:0], req_size);
   assign in_cache       = (req_addr[31:0] >= CACHE_BASE) && (req_addr[31:0] <= CACHE_LIMIT);
   assign ld_raw         = (state_q == ST_DEV) ? dev_rdata : cache_rdata;

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .st_off_i      (req_addr[2:0]),
      .st_size_i     (req_size),
      .st_wdata_i    (req_wdata),
      .st_wdata_o    (st_wdata),
      .st_wmask_o    (st_wmask),
      .ld_off_i      (off_q),
      .ld_size_i     (size_q),
      .ld_unsigned_i (uns_q),
      .ld_raw_i      (ld_raw),
      .ld_data_o     (ld_data)
   );

`ifdef LSU_DEV_TIMEOUT_EN
   logic [31:0] tmo_q;
   logic        tmo_hit;

   assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));

   // Held at zero outside DEV, so it starts from zero on every entry.
   always_ff @(posedge clk) begin
      if (rst || state_q != ST_DEV) tmo_q <= '0;
      else                          tmo_q <= tmo_q + 32'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (misal)         state_d = ST_RESP;
               else if (in_cache) state_d = ST_CACHE;
               else               state_d = ST_DEV;
            end
         end
         ST_CACHE: if (cache_finish) state_d = ST_RESP;
         ST_DEV: begin
            if (dev_finish) state_d = ST_RESP;
`ifdef LSU_DEV_TIMEOUT_EN
            else if (tmo_hit) state_d = ST_RESP;
`endif
         end
         ST_RESP: if (resp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= '0;
         off_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  wen_q   <= req_wen;
                  uns_q   <= req_unsigned;
                  err_q   <= misal;
                  size_q  <= req_size;
                  off_q   <= req_addr[2:0];
                  addr_q  <= {req_addr[31:3], 3'b000};
                  wdata_q <= st_wdata;
                  wmask_q <= st_wmask;
                  rdata_q <= '0;
               end
            end
            ST_CACHE: if (cache_finish) rdata_q <= wen_q ? '0 : ld_data;
            ST_DEV: begin
               if (dev_finish) rdata_q <= wen_q ? '0 : ld_data;
`ifdef LSU_DEV_TIMEOUT_EN
               else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready   = (state_q == ST_IDLE);
      resp_valid  = (state_q == ST_RESP);
      resp_rdata  = rdata_q;
      resp_err    = err_q;
      cache_req   = 1'b0;
      cache_wen   = 1'b0;
      cache_addr  = '0;
      cache_wdata = '0;
      cache_wmask = '0;
      dev_req     = 1'b0;
      dev_wen     = 1'b0;
      dev_addr    = '0;
      dev_wdata   = '0;
      dev_wmask   = '0;
      if (state_q == ST_CACHE) begin
         cache_req   = 1'b1;
         cache_wen   = wen_q;
         cache_addr  = addr_q;
         cache_wdata = wdata_q;
         cache_wmask = wmask_q;
      end
      if (state_q == ST_DEV) begin
         dev_req   = 1'b1;
         dev_wen   = wen_q;
         dev_addr  = addr_q;
         dev_wdata = wdata_q;
         dev_wmask = wmask_q;
      end
   end

endmodule

// File: tb/tb_lsu_router.sv
// Directed and randomized transactions against a byte-level reference model of the load/store router.
module tb_lsu_router;

   localparam logic [31:0] CB = 32'h8000_0000;
   localparam logic [31:0] CL = 32'h87ff_ffff;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_wen, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [63:0] resp_rdata;
   logic        cache_req, cache_wen, cache_finish;
   logic [31:0] cache_addr;
   logic [63:0] cache_wdata, cache_rdata;
   logic [7:0]  cache_wmask;
   logic        dev_req, dev_wen, dev_finish;
   logic [31:0] dev_addr;
   logic [63:0] dev_wdata, dev_rdata;
   logic [7:0]  dev_wmask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_router dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .cache_req(cache_req), .cache_wen(cache_wen), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
      .cache_wmask(cache_wmask), .cache_rdata(cache_rdata), .cache_finish(cache_finish),
      .dev_req(dev_req), .dev_wen(dev_wen), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_wmask(dev_wmask), .dev_rdata(dev_rdata), .dev_finish(dev_finish)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called and returns at a negedge; drives one request and plays the memory side.
   task automatic run_txn(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] raw,
                          input int delay, input int hold, input logic preload);
      int          n;
      int          off;
      logic        misal, to_cache;
      logic [31:0] a32;
      logic [7:0]  exp_m;
      logic [63:0] exp_wd, exp_rd;
      n        = 1 << size;
      off      = int'(addr[2:0]);
      a32      = addr[31:0];
      misal    = (off % n) != 0;
      to_cache = (a32 >= CB) && (a32 <= CL);
      exp_m    = '0;
      exp_rd   = '0;
      exp_wd   = wdata << (8 * off);
      if (!misal) begin
         for (int j = 0; j < n; j++) begin
            exp_m[off + j] = 1'b1;
            if (!wen) exp_rd = exp_rd | (64'(raw[8 * (off + j) +: 8]) << (8 * j));
         end
         if (!wen && !uns && n < 8 && exp_rd[8 * n - 1]) exp_rd = exp_rd | (~64'd0 << (8 * n));
      end

      req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      chk("req_ready_idle", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      if (misal) begin
         chk("misal_resp_valid", resp_valid, 1);
         chk("misal_cache_req", cache_req, 0);
         chk("misal_dev_req", dev_req, 0);
      end else begin
         for (int c = 0; c <= delay; c++) begin
            chk("wait_resp_valid", resp_valid, 0);
            chk("wait_req_ready", req_ready, 0);
            if (to_cache) begin
               chk("cache_req", cache_req, 1);
               chk("cache_addr", cache_addr, {a32[31:3], 3'b000});
               chk("cache_wmask", cache_wmask, exp_m);
               chk("cache_wdata", cache_wdata, exp_wd);
               chk("cache_wen", cache_wen, wen);
               chk("dev_idle", {dev_req, dev_wen, dev_wmask, dev_addr}, 0);
            end else begin
               chk("dev_req", dev_req, 1);
               chk("dev_addr", dev_addr, {a32[31:3], 3'b000});
               chk("dev_wmask", dev_wmask, exp_m);
               chk("dev_wdata", dev_wdata, exp_wd);
               chk("dev_wen", dev_wen, wen);
               chk("cache_idle", {cache_req, cache_wen, cache_wmask, cache_addr}, 0);
            end
            if (c == delay) begin
               cache_finish = to_cache;
               dev_finish   = !to_cache;
               cache_rdata  = to_cache ? raw : {$urandom, $urandom};
               dev_rdata    = to_cache ? {$urandom, $urandom} : raw;
            end else begin
               // stray finish on the idle port must be ignored
               cache_finish = !to_cache && ($urandom_range(1, 0) == 1);
               dev_finish   = to_cache && ($urandom_range(1, 0) == 1);
               cache_rdata  = {$urandom, $urandom};
               dev_rdata    = {$urandom, $urandom};
            end
            @(negedge clk);
            cache_finish = 1'b0; dev_finish = 1'b0;
            cache_rdata = {$urandom, $urandom}; dev_rdata = {$urandom, $urandom};
         end
         chk("resp_valid", resp_valid, 1);
         chk("req_dropped", {cache_req, dev_req}, 0);
      end
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", resp_err, misal);
      for (int h = 0; h < hold; h++) begin
         if (preload) req_valid = 1'b1;
         @(negedge clk);
         chk("hold_resp_valid", resp_valid, 1);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_rdata", resp_rdata, exp_rd);
         chk("hold_err", resp_err, misal);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("post_resp_valid", resp_valid, 0);
      chk("post_req_ready", req_ready, 1);
   endtask

   initial begin
      logic [63:0] a;
      logic [31:0] bnd [6];
      bnd[0] = 32'h8000_0000; bnd[1] = 32'h87ff_fff8; bnd[2] = 32'h8800_0000;
      bnd[3] = 32'h7fff_fff8; bnd[4] = 32'h87ff_ffff; bnd[5] = 32'hffff_fff8;

      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      cache_rdata = '0; cache_finish = 1'b0; dev_rdata = '0; dev_finish = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_reqs", {cache_req, dev_req, cache_wen, dev_wen}, 0);
      chk("rst_cache_regs", {cache_addr, cache_wmask}, 0);
      chk("rst_cache_wdata", cache_wdata, 0);
      rst = 1'b0;

      // signed byte load from cache
      run_txn(1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_8F00_0000, 0, 0, 1'b0);
      // device half store, finish in fifth wait cycle
      run_txn(1'b1, 2'd1, 1'b0, 64'h0000_0000_A000_0006, 64'h1234, 64'hDEAD_BEEF_0BAD_F00D, 4, 0, 1'b0);
      // misaligned word load
      run_txn(1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0002, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 1'b0);
      // cache window edges
      run_txn(1'b0, 2'd3, 1'b0, 64'h0000_0000_87ff_fff8, 64'h0, 64'h8877_6655_4433_2211, 1, 0, 1'b0);
      run_txn(1'b0, 2'd2, 1'b1, 64'h0000_0000_8800_0004, 64'h0, 64'hF000_0001_0000_0000, 0, 0, 1'b0);
      // response backpressure with next request already waiting
      run_txn(1'b0, 2'd1, 1'b0, 64'h0000_0000_8000_0102, 64'h0, 64'h0000_0000_8001_0000, 0, 4, 1'b1);
      run_txn(1'b0, 2'd1, 1'b0, 64'h0000_0000_8000_0102, 64'h0, 64'h0000_0000_8001_0000, 2, 0, 1'b0);

      // reset during cache wait; late finish is ignored
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0010;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid_cache_req", cache_req, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_cache_drop", cache_req, 0);
      chk("rst_mid_resp_valid", resp_valid, 0);
      chk("rst_mid_req_ready", req_ready, 1);
      @(negedge clk);
      cache_finish = 1'b1; cache_rdata = 64'h5555_AAAA_5555_AAAA;
      @(negedge clk);
      cache_finish = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_finish_resp_valid", resp_valid, 0);
         chk("late_finish_req_ready", req_ready, 1);
         chk("late_finish_cache_req", cache_req, 0);
         @(negedge clk);
      end

`ifdef LSU_DEV_TIMEOUT_EN
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_addr = 64'h1000_0000;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 255; c++) begin
         if (c == 0 || c == 254) chk("tmo_dev_req", dev_req, 1);
         if (c == 254) chk("tmo_no_resp", resp_valid, 0);
         @(negedge clk);
      end
      chk("tmo_resp_valid", resp_valid, 1);
      chk("tmo_resp_err", resp_err, 1);
      chk("tmo_resp_rdata", resp_rdata, 0);
      chk("tmo_dev_drop", dev_req, 0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
`endif

      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(2, 0))
            0:       a = {$urandom, CB + ($urandom % 32'h0800_0000)};
            1:       a = {$urandom, $urandom};
            default: a = {32'h0, bnd[$urandom_range(5, 0)] | 32'($urandom_range(7, 0))};
         endcase
         run_txn(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 a, {$urandom, $urandom}, {$urandom, $urandom},
                 int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_router.md
Name: lsu_router

Overview:
Next-generation load/store routing unit for the NPC memory stage.
- Accepts one load or store per valid/ready handshake and registers it.
- Decodes the address into a cacheable region (sent to dcache) or a device region (sent to the uncached device port).
- Performs byte-lane alignment and builds the write mask internally.
- Sign- or zero-extends load data, then returns the result on a valid/ready response channel.
- Reports misaligned accesses as an error; misaligned requests never reach memory.

Parameters:
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 64, data width; must be 64 (8 byte lanes)
- CACHE_BASE, 32'h80000000, lowest cacheable address (compared against addr[31:0])
- CACHE_LIMIT, 32'h87ffffff, highest cacheable address, inclusive

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  zero-extend the load (lbu/lhu/lwu)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
- resp_err  out  1  misaligned access
- cache_req  out  1  cache access request, held until cache_finish
- cache_wen  out  1  cache write
- cache_addr  out  32  8-byte aligned address
- cache_wdata  out  DATA_WIDTH  lane-shifted write data
- cache_wmask  out  8  byte strobes
- cache_rdata  in  DATA_WIDTH  raw 8-byte line word
- cache_finish  in  1  one-cycle completion pulse
- dev_req, dev_wen, dev_addr, dev_wdata, dev_wmask  out  same widths as cache_*  device port
- dev_rdata  in  DATA_WIDTH
- dev_finish  in  1  one-cycle completion pulse

Behaviour:
- Reset: state = IDLE; req_ready = 1; resp_valid, resp_err, cache_req, dev_req, all wen signals = 0; all data, address and mask registers = 0.
- Reset mid-operation aborts the transaction. Requests drop the next cycle; a finish pulse arriving later is ignored in IDLE.
- States: IDLE, CACHE, DEV, RESP.
- IDLE:
  - On req_valid, latch the whole request and decode it (offset = addr[2:0]).
  - Misaligned means offset is not a multiple of 2^size. A misaligned request goes to RESP with resp_err = 1, rdata = 0, and no downstream request.
  - Otherwise: addr[31:0] in [CACHE_BASE, CACHE_LIMIT] goes to CACHE; everything else goes to DEV.
  - Decode uses only req_addr, never a separate write address.
- CACHE/DEV:
  - The selected *_req is high from the cycle after acceptance until the cycle its *_finish is sampled high.
  - *_addr = {addr[31:3], 3'b0}.
  - wmask = ((1 << 2^size) - 1) << offset. wdata = req_wdata << (offset*8).
  - On finish: capture rdata >> (offset*8), truncate to the access size, and extend (sign unless req_unsigned). Go to RESP.
  - The unselected port stays idle with all of its outputs at 0.
- RESP: resp_valid = 1; hold all response fields stable until resp_ready, then return to IDLE.
- No back-to-back bypass: a new request can be accepted no earlier than the cycle after resp handshake.
- Minimum latency, accept to resp_valid:
  - 2 cycles for an aligned access, with finish arriving in the first wait cycle.
  - 1 cycle for a misaligned access.
- A finish on the unselected port is ignored.
- Stores return resp_rdata = 0.

Optional Feature:
- LSU_DEV_TIMEOUT_EN: adds parameter TIMEOUT_CYCLES (default 255) and a counter that runs while in DEV.
  - If dev_finish has not arrived after TIMEOUT_CYCLES cycles: drop dev_req, go to RESP with resp_err = 1 and rdata = 0.
  - The counter clears on entering DEV.
- Without the macro, DEV waits indefinitely and resp_err means misalignment only.

Decomposition:
- Package lsu_pkg holds:
  - size encoding constants SZ_B/SZ_H/SZ_W/SZ_D
  - state typedef lsu_state_t
  - default CACHE_BASE and CACHE_LIMIT constants
- One sub-module: lsu_align. It is purely combinational and contains:
  - store lane shift and mask generation
  - load lane shift, truncation and extension
- The FSM, request registers and port muxing stay in lsu_router.

Test Plan:
1. Load byte, signed, addr 0x80000003; cache_rdata = 0x00000000_8F000000; finish one cycle later -> cache_addr 0x80000000; resp_rdata 0xFFFFFFFF_FFFFFF8F; resp_err 0; dev_req never high.
2. Store half, addr 0xA0000006, wdata 0x1234 -> dev_req high; dev_wmask 0xC0; dev_wdata 0x12340000_00000000; finish after 5 cycles; resp_valid one cycle later; resp_rdata 0.
3. Load word at 0x80000002 -> no cache_req and no dev_req; resp_valid the next cycle with resp_err 1 and rdata 0.
4. Load at CACHE_LIMIT-7 (0x87fffff8) routes to cache; load at 0x88000000 routes to device.
5. Hold resp_ready low for 4 cycles -> resp fields stable and req_ready 0 throughout. A req_valid asserted during that time is only accepted after the handshake.
6. Assert rst during CACHE wait, then pulse cache_finish 2 cycles later -> cache_req 0 the cycle after reset, no resp_valid, req_ready 1. With LSU_DEV_TIMEOUT_EN, a device load with no finish gives resp_err 1 after 255 cycles.
